// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// Memory pipeline stage: load/store/push/pop/jsr-push/exception-push as a single bus master; optional MEM_ALIGN_CHECK_EN.
// Latency: 1 cycle pass-through; 3 cycles for a zero-wait bus access, plus 1 per wait state.
// Backpressure: stall_o holds upstream while an access is starting or outstanding; stall_i holds this stage's outputs.
module mem_stage #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] result_i,
    input  logic [31:0] reg_data1_i,
    input  logic [1:0]  reg_write_i,
    input  logic [1:0]  sp_write_i,
    input  logic [31:0] sp_data_i,
    input  logic        exc_i,
    input  logic        stall_i,
    output logic        stall_o,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o,
    output logic [31:0] result_o,
    output logic [1:0]  reg_write_o,
    output logic [1:0]  sp_write_o,
    output logic [31:0] sp_data_o,
    output logic        fault_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    // Instruction type encodings in ir[31:28]
    localparam logic [3:0] T_LOAD  = 4'h2;
    localparam logic [3:0] T_STORE = 4'h3;
    localparam logic [3:0] T_PUSH  = 4'h4;
    localparam logic [3:0] T_POP   = 4'h5;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic [63:0]   ir_q, ir_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   result_q, result_d;
    logic [1:0]    rw_q, rw_d;
    logic [1:0]    spw_q, spw_d;
    logic [31:0]   spd_q, spd_d;

    logic [3:0]    typ, op;
    logic          acc, acc_we;
    logic [31:0]   acc_adr, acc_wdat, acc_wrep, rd_ext;
    logic [1:0]    acc_size;
    logic [3:0]    acc_sel;
    logic          misalign;
    logic          ld_out;

    assign typ = ir_i[31:28];
    assign op  = ir_i[27:24];

    // Exception entry overrides whatever the instruction would have done
    always_comb begin
        acc      = 1'b0;
        acc_we   = 1'b0;
        acc_adr  = result_i;
        acc_size = SZ_WORD;
        acc_wdat = reg_data1_i;
        if (exc_i) begin
            acc      = 1'b1;
            acc_we   = 1'b1;
            acc_adr  = sp_data_i;
            acc_wdat = pc_i;
        end else begin
            case (typ)
                T_LOAD: begin
                    acc      = 1'b1;
                    acc_size = op[1:0];
                end
                T_STORE: begin
                    acc      = 1'b1;
                    acc_we   = 1'b1;
                    acc_size = op[1:0];
                end
                T_PUSH: begin
                    if (op == 4'd0 || op == 4'd1 || op == 4'd2) begin
                        acc     = 1'b1;
                        acc_we  = 1'b1;
                        acc_adr = sp_data_i;
                    end
                    if (op == 4'd1 || op == 4'd2) acc_wdat = pc_i;
                end
                T_POP: begin
                    acc     = 1'b1;
                    acc_adr = sp_data_i - 32'd4;
                end
                default: acc = 1'b0;
            endcase
        end
    end

    // Big-endian lanes: sel[3] carries byte address 0
    always_comb begin
        case (acc_size)
            SZ_HALF: begin
                acc_sel  = acc_adr[1] ? 4'b0011 : 4'b1100;
                acc_wrep = {2{acc_wdat[15:0]}};
            end
            SZ_BYTE: begin
                acc_sel  = 4'b1000 >> acc_adr[1:0];
                acc_wrep = {4{acc_wdat[7:0]}};
            end
            default: begin
                acc_sel  = 4'b1111;
                acc_wrep = acc_wdat;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (acc_size == SZ_HALF) ? acc_adr[0] :
                      (acc_size == SZ_BYTE) ? 1'b0 : (acc_adr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        case (size_q)
            SZ_HALF: rd_ext = {16'h0, adr_q[1] ? bus_dat_i[15:0] : bus_dat_i[31:16]};
            SZ_BYTE: begin
                case (adr_q[1:0])
                    2'd0:    rd_ext = {24'h0, bus_dat_i[31:24]};
                    2'd1:    rd_ext = {24'h0, bus_dat_i[23:16]};
                    2'd2:    rd_ext = {24'h0, bus_dat_i[15:8]};
                    default: rd_ext = {24'h0, bus_dat_i[7:0]};
                endcase
            end
            default: rd_ext = bus_dat_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        ld_out  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (acc && !stall_i) begin
                    we_d    = acc_we;
                    adr_d   = acc_adr;
                    sel_d   = acc_sel;
                    dat_d   = acc_wrep;
                    size_d  = acc_size;
                    rdata_d = 32'h0;
                    if (misalign) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cyc_d   = 1'b1;
                        state_d = S_BUS;
                    end
                end else if (!stall_i) begin
                    ld_out = 1'b1;
                end
            end
            S_BUS: begin
                // Ack wins over a timeout expiring in the same cycle
                if (bus_ack_i) begin
                    cyc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!we_q) rdata_d = rd_ext;
                end else if (BUS_TIMEOUT != 0 && cnt_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (!stall_i) begin
                    ld_out  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ir_d     = ld_out ? ir_i        : ir_q;
        pc_d     = ld_out ? pc_i        : pc_q;
        rw_d     = ld_out ? reg_write_i : rw_q;
        spw_d    = ld_out ? sp_write_i  : spw_q;
        spd_d    = ld_out ? sp_data_i   : spd_q;
        result_d = result_q;
        if (ld_out) result_d = (state_q == S_DONE && !we_q) ? rdata_q : result_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 32'h0;
            sel_q    <= 4'h0;
            dat_q    <= 32'h0;
            size_q   <= SZ_WORD;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            ir_q     <= 64'h0;
            pc_q     <= 32'h0;
            result_q <= 32'h0;
            rw_q     <= 2'b0;
            spw_q    <= 2'b0;
            spd_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            size_q   <= size_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            result_q <= result_d;
            rw_q     <= rw_d;
            spw_q    <= spw_d;
            spd_q    <= spd_d;
        end
    end

    assign stall_o     = !rst_i && ((state_q == S_IDLE && acc && !stall_i) || state_q == S_BUS);
    assign ir_o        = ir_q;
    assign pc_o        = pc_q;
    assign result_o    = result_q;
    assign reg_write_o = rw_q;
    assign sp_write_o  = spw_q;
    assign sp_data_o   = spd_q;
    assign fault_o     = fault_q;
    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_adr_o   = adr_q;
    assign bus_sel_o   = sel_q;
    assign bus_dat_o   = dat_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Bench for mem_stage: bus slave model with expected-transaction queue plus expected-output queue.
module tb_mem_stage;

    localparam logic [3:0] T_ALU = 4'h0, T_LOAD = 4'h2, T_STORE = 4'h3, T_PUSH = 4'h4, T_POP = 4'h5;
    localparam logic [63:0] NOP = 64'h0;

    logic        clk, rst_i;
    logic [63:0] ir_i;
    logic [31:0] pc_i, result_i, reg_data1_i, sp_data_i;
    logic [1:0]  reg_write_i, sp_write_i;
    logic        exc_i, stall_i, stall_o;
    logic [63:0] ir_o;
    logic [31:0] pc_o, result_o, sp_data_o;
    logic [1:0]  reg_write_o, sp_write_o;
    logic        fault_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
    logic [3:0]  bus_sel_o;

    mem_stage #(.BUS_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i),
        .reg_data1_i(reg_data1_i), .reg_write_i(reg_write_i), .sp_write_i(sp_write_i),
        .sp_data_i(sp_data_i), .exc_i(exc_i), .stall_i(stall_i), .stall_o(stall_o),
        .ir_o(ir_o), .pc_o(pc_o), .result_o(result_o), .reg_write_o(reg_write_o),
        .sp_write_o(sp_write_o), .sp_data_o(sp_data_o), .fault_o(fault_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_t;

    typedef struct packed {
        logic [63:0] ir;
        logic [31:0] pc;
        logic [1:0]  rw;
        logic [1:0]  spw;
        logic [31:0] spd;
        logic [31:0] res;
    } out_t;

    bus_t bus_q[$];
    out_t out_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   bus_waits = 0;
    bit   bus_ack_en = 1'b1;
    bit   stray_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    wire [236:0] all_out = {ir_o, pc_o, result_o, reg_write_o, sp_write_o, sp_data_o, fault_o,
                            bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o, stall_o};

    function automatic logic [63:0] mk(input logic [3:0] t, input logic [3:0] op);
        mk = {32'hA5A5_0F0F, t, op, 24'h00BEEF};
    endfunction

    task automatic exp_bus(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
        bus_t b;
        b = '{adr: adr, we: we, sel: sel, dat: dat};
        bus_q.push_back(b);
    endtask

    // Slave: checks each new transaction against the queue, acks after bus_waits cycles
    initial begin : slave
        bit   in_txn;
        int   wcnt;
        bus_t e;
        in_txn = 1'b0;
        wcnt = 0;
        bus_ack_i = 1'b0;
        bus_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_cyc_o && bus_stb_o) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wcnt = 0;
                    n_cmp++;
                    if (bus_q.size() == 0) begin
                        n_err++;
                        $display("FAIL bus_unexpected: got adr=%h we=%b sel=%b, required no transaction",
                                 bus_adr_o, bus_we_o, bus_sel_o);
                    end else begin
                        e = bus_q.pop_front();
                        if ({bus_adr_o, bus_we_o, bus_sel_o} !== {e.adr, e.we, e.sel} ||
                            (e.we && bus_dat_o !== e.dat)) begin
                            n_err++;
                            $display("FAIL bus_txn: got adr=%h we=%b sel=%b dat=%h, required adr=%h we=%b sel=%b dat=%h",
                                     bus_adr_o, bus_we_o, bus_sel_o, bus_dat_o, e.adr, e.we, e.sel, e.dat);
                        end
                    end
                end
                bus_ack_i = bus_ack_en && (wcnt >= bus_waits);
                bus_dat_i = bus_rdata;
                wcnt++;
            end else begin
                in_txn = 1'b0;
                bus_ack_i = stray_ack;
            end
        end
    end

    // Called at a negedge; returns at the following negedge with a NOP driven
    task automatic issue(input logic [63:0] ir, input logic [31:0] pc, input logic [31:0] res,
                         input logic [31:0] d1, input logic [31:0] spd, input logic [1:0] rw,
                         input logic [1:0] spw, input logic exc, input logic [31:0] exp_res,
                         output int stall_cyc, output int fault_cnt);
        out_t e;
        bit   s;
        bit   done;
        ir_i = ir; pc_i = pc; result_i = res; reg_data1_i = d1; sp_data_i = spd;
        reg_write_i = rw; sp_write_i = spw; exc_i = exc; stall_i = 1'b0; rst_i = 1'b0;
        e = '{ir: ir, pc: pc, rw: rw, spw: spw, spd: spd, res: exp_res};
        out_q.push_back(e);
        stall_cyc = 0;
        fault_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            s = stall_o;
            if (s) stall_cyc++;
            @(posedge clk);
            #1;
            if (fault_o) fault_cnt++;
            if (!s) begin
                done = 1'b1;
                e = out_q.pop_front();
                n_cmp++;
                if ({ir_o, pc_o, reg_write_o, sp_write_o, sp_data_o} !== {e.ir, e.pc, e.rw, e.spw, e.spd}) begin
                    n_err++;
                    $display("FAIL out_fields: got ir=%h pc=%h rw=%b spw=%b spd=%h, required ir=%h pc=%h rw=%b spw=%b spd=%h",
                             ir_o, pc_o, reg_write_o, sp_write_o, sp_data_o, e.ir, e.pc, e.rw, e.spw, e.spd);
                end
                n_cmp++;
                if (result_o !== e.res) begin
                    n_err++;
                    $display("FAIL out_result: got %h, required %h", result_o, e.res);
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: stall_o still %b after 64 cycles, required 0", stall_o);
            if (out_q.size() > 0) void'(out_q.pop_front());
        end
        @(negedge clk);
        ir_i = NOP;
        exc_i = 1'b0;
    endtask

    task automatic chk_lat(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; stall_i = 1'b0; exc_i = 1'b0;
        ir_i = mk(T_LOAD, 4'd0); pc_i = 32'h0; result_i = 32'h1000; reg_data1_i = 32'h0;
        sp_data_i = 32'h0; reg_write_i = 2'b0; sp_write_i = 2'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required all zero", all_out);
        end
        @(negedge clk);
        rst_i = 1'b0;
        ir_i = NOP;
    endtask

    task automatic test_passthru();
        int sc, fc;
        issue({32'hCAFE_0000, T_ALU, 4'h3, 24'h123456}, 32'h100, 32'h1234_5678, 32'h0, 32'h2000,
              2'b01, 2'b00, 1'b0, 32'h1234_5678, sc, fc);
        chk_lat("alu_latency", sc, 0);
        issue({32'hCAFE_0001, T_ALU, 4'h1, 24'h000001}, 32'h104, 32'h0000_0042, 32'h0, 32'h1FFC,
              2'b10, 2'b01, 1'b0, 32'h0000_0042, sc, fc);
        chk_lat("alu_b2b_latency", sc, 0);
    endtask

    task automatic test_exc_deferred();
        int sc, fc;
        ir_i = {32'h0, T_ALU, 4'h0, 24'h0}; pc_i = 32'h80; sp_data_i = 32'h3FC; exc_i = 1'b1;
        result_i = 32'h7; stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (stall_o !== 1'b0) begin
                n_err++;
                $display("FAIL exc_stall_o: got %b, required 0 while stall_i", stall_o);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus_cyc_o !== 1'b0 || pc_o !== 32'h104) begin
                n_err++;
                $display("FAIL exc_deferred: got cyc=%b pc_o=%h, required cyc=0 pc_o=00000104", bus_cyc_o, pc_o);
            end
            @(negedge clk);
        end
        exp_bus(32'h3FC, 1'b1, 4'hF, 32'h80);
        issue({32'h0, T_ALU, 4'h0, 24'h0}, 32'h80, 32'h7, 32'h0, 32'h3FC, 2'b00, 2'b01, 1'b1,
              32'h7, sc, fc);
        chk_lat("exc_latency", sc, 2);
    endtask

    task automatic test_load();
        int sc, fc;
        bus_waits = 0;
        bus_rdata = 32'hDEAD_BEEF;
        exp_bus(32'h1000, 1'b0, 4'hF, 32'h0);
        issue(mk(T_LOAD, 4'd0), 32'h200, 32'h1000, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 32'hDEAD_BEEF, sc, fc);
        chk_lat("load_word_stall", sc, 2);
        bus_rdata = 32'h1234_ABCD;
        exp_bus(32'h1002, 1'b0, 4'b0011, 32'h0);
        issue(mk(T_LOAD, 4'd1), 32'h204, 32'h1002, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 32'h0000_ABCD, sc, fc);
        bus_rdata = 32'hDEAD_BEEF;
        exp_bus(32'h1001, 1'b0, 4'b0100, 32'h0);
        issue(mk(T_LOAD, 4'd2), 32'h208, 32'h1001, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 32'h0000_00AD, sc, fc);
    endtask

    task automatic test_store();
        int sc, fc;
        exp_bus(32'h2003, 1'b1, 4'b0001, 32'hABAB_ABAB);
        issue(mk(T_STORE, 4'd2), 32'h300, 32'h2003, 32'h1234_56AB, 32'h0, 2'b00, 2'b00, 1'b0, 32'h2003, sc, fc);
        chk_lat("store_byte_stall", sc, 2);
        issue({32'h0, T_ALU, 4'h0, 24'h000777}, 32'h304, 32'h99, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 32'h99, sc, fc);
        chk_lat("resume_after_store", sc, 0);
        exp_bus(32'h2000, 1'b1, 4'b1100, 32'h5678_5678);
        issue(mk(T_STORE, 4'd1), 32'h308, 32'h2000, 32'h9999_5678, 32'h0, 2'b00, 2'b00, 1'b0, 32'h2000, sc, fc);
    endtask

    task automatic test_push_pop();
        int sc, fc;
        exp_bus(32'hFF8, 1'b1, 4'hF, 32'h1111_2222);
        issue(mk(T_PUSH, 4'd0), 32'h3FC, 32'h0, 32'h1111_2222, 32'hFF8, 2'b00, 2'b01, 1'b0, 32'h0, sc, fc);
        exp_bus(32'hFFC, 1'b1, 4'hF, 32'h400);
        issue(mk(T_PUSH, 4'd1), 32'h400, 32'h5000, 32'hFFFF_FFFF, 32'hFFC, 2'b00, 2'b01, 1'b0, 32'h5000, sc, fc);
        bus_rdata = 32'h5566_7788;
        exp_bus(32'hFFC, 1'b0, 4'hF, 32'h0);
        issue(mk(T_POP, 4'd0), 32'h404, 32'h0, 32'h0, 32'h1000, 2'b01, 2'b01, 1'b0, 32'h5566_7788, sc, fc);
    endtask

    task automatic test_wait_states();
        int sc, fc;
        bus_waits = 2;
        bus_rdata = 32'h0BAD_F00D;
        exp_bus(32'h3000, 1'b0, 4'hF, 32'h0);
        issue(mk(T_LOAD, 4'd0), 32'h500, 32'h3000, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 32'h0BAD_F00D, sc, fc);
        chk_lat("wait2_stall", sc, 4);
        bus_waits = 0;
    endtask

    task automatic test_timeout();
        int sc, fc;
        bus_ack_en = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
        exp_bus(32'h4000, 1'b0, 4'hF, 32'h0);
        issue(mk(T_LOAD, 4'd0), 32'h600, 32'h4000, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 32'h0, sc, fc);
        chk_lat("timeout_stall", sc, 5);
        chk_lat("timeout_fault_pulses", fc, 1);
        n_cmp++;
        if (bus_cyc_o !== 1'b0 || fault_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_after: got cyc=%b fault=%b, required 0 0", bus_cyc_o, fault_o);
        end
        bus_ack_en = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        bus_ack_en = 1'b0;
        exp_bus(32'h5000, 1'b0, 4'hF, 32'h0);
        ir_i = mk(T_LOAD, 4'd0); pc_i = 32'h700; result_i = 32'h5000; stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus_cyc_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_access_cyc: got %b, required 1", bus_cyc_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_mid_access: got %h, required all zero", all_out);
        end
        @(negedge clk);
        rst_i = 1'b0;
        ir_i = NOP; pc_i = 32'h800; result_i = 32'h0; sp_data_i = 32'h0;
        reg_write_i = 2'b0; sp_write_i = 2'b0;
        stray_ack = 1'b1;
        bus_ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus_cyc_o !== 1'b0 || stall_o !== 1'b0 || pc_o !== 32'h800) begin
            n_err++;
            $display("FAIL late_ack_ignored: got cyc=%b stall=%b pc_o=%h, required 0 0 00000800",
                     bus_cyc_o, stall_o, pc_o);
        end
        @(negedge clk);
        stray_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthru();
        test_exc_deferred();
        test_load();
        test_store();
        test_push_pop();
        test_wait_states();
        test_timeout();
        test_reset_mid_access();
        n_cmp++;
        if (bus_q.size() != 0) begin
            n_err++;
            $display("FAIL bus_leftover: got %0d pending, required 0", bus_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
